// File: rtl/bomb_sequencer.sv
// Round sequencer for the bomb-defusal board. It runs the countdown timer,
// the strike counter and the sticky solved mask, and decides win or lose.
// It also picks which minigame drives the OLED and holds every minigame in
// reset except during an armed round.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | start screen; arm starts a round and loads the counters
// ARMED    | round running; timer ticks, strikes and solves are accepted
// DEFUSED  | every module solved in time; counters frozen until arm
// EXPLODED | out of time or too many strikes; counters frozen until arm
module bomb_sequencer #(
  parameter int NUM_MODULES     = 3,
  parameter int CLK_HZ          = 100_000_000,
  parameter int TIME_SECONDS    = 300,
  parameter int MAX_STRIKES     = 3,
  parameter int PENALTY_SECONDS = 10
) (
  input  logic                      basys_clock,
  input  logic                      reset_n,
  input  logic                      arm,
  input  logic [NUM_MODULES-1:0]    module_solved,
  input  logic [NUM_MODULES-1:0]    module_strike,
  input  logic [16*NUM_MODULES-1:0] module_pixel,
  input  logic [15:0]               home_pixel,
  output logic [15:0]               oled_data,
  output logic                      module_hold,
  output logic [3:0]                active_module,
  output logic [1:0]                state,
  output logic [9:0]                seconds_left,
  output logic [1:0]                strikes,
  output logic [15:0]               led
);

  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(CLK_HZ - 1);
  localparam logic [9:0]    ROUND_TIME    = 10'(TIME_SECONDS);
  localparam logic [31:0]   PENALTY       = 32'(PENALTY_SECONDS);
  localparam logic [31:0]   STRIKE_LIMIT  = 32'(MAX_STRIKES);

  localparam logic [15:0] PIXEL_DEFUSED  = 16'h07E0;
  localparam logic [15:0] PIXEL_EXPLODED = 16'hF800;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    DEFUSED  = 2'd2,
    EXPLODED = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [PW-1:0]          prescaler;
  logic [NUM_MODULES-1:0] solved_reg;
  logic                   blink;

  logic                   tick;
  logic                   strike_any;
  logic [NUM_MODULES-1:0] solved_next;
  logic                   all_solved;
  logic [1:0]             strikes_next;
  logic [31:0]            deduct;
  logic [9:0]             seconds_left_next;
  logic                   boom;
  logic [3:0]             first_unsolved;

  // Next-cycle values of the round counters, shared by the FSM and datapath.
  always_comb begin
    tick        = (state_q == ARMED) && (prescaler == PRESCALE_LAST);
    strike_any  = |module_strike;
    solved_next = solved_reg | module_solved;
    all_solved  = &solved_next;

    // Several strike bits in one cycle still count as a single strike.
    strikes_next = strikes + {1'b0, strike_any};

    // Tick and penalty stack; the timer saturates at zero instead of wrapping.
    deduct = {31'd0, tick} + (strike_any ? PENALTY : 32'd0);
    if ({22'd0, seconds_left} <= deduct) begin
      seconds_left_next = 10'd0;
    end else begin
      seconds_left_next = seconds_left - deduct[9:0];
    end

    boom = ({30'd0, strikes_next} >= STRIKE_LIMIT) || (seconds_left_next == 10'd0);

    // Lowest unsolved module; scanning downward lets the lowest index win.
    // With everything solved the current selection is kept.
    first_unsolved = active_module;
    for (int i = NUM_MODULES - 1; i >= 0; i--) begin
      if (!solved_next[i]) begin
        first_unsolved = 4'(i);
      end
    end
  end

  // State register.
  always_ff @(posedge basys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a detonation outranks a defuse in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (boom) begin
          state_d = EXPLODED;
        end else if (all_solved) begin
          state_d = DEFUSED;
        end
      end
      DEFUSED, EXPLODED: begin
        if (arm) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Round datapath: loaded on arm, updated while armed, frozen otherwise.
  always_ff @(posedge basys_clock or negedge reset_n) begin
    if (!reset_n) begin
      prescaler     <= '0;
      seconds_left  <= 10'd0;
      strikes       <= 2'd0;
      solved_reg    <= '0;
      active_module <= 4'd0;
      blink         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          active_module <= 4'd0;
          if (arm) begin
            prescaler    <= '0;
            seconds_left <= ROUND_TIME;
            strikes      <= 2'd0;
            solved_reg   <= '0;
            blink        <= 1'b1;
          end
        end
        ARMED: begin
          prescaler     <= tick ? '0 : prescaler + 1'b1;
          seconds_left  <= seconds_left_next;
          strikes       <= strikes_next;
          solved_reg    <= solved_next;
          active_module <= first_unsolved;
          if (tick) begin
            blink <= ~blink;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Display mux and module reset hold.
  always_comb begin
    state       = state_q;
    module_hold = (state_q != ARMED);
    oled_data   = home_pixel;
    case (state_q)
      IDLE: oled_data = home_pixel;
      ARMED: begin
        oled_data = 16'h0000;
        for (int i = 0; i < NUM_MODULES; i++) begin
          if (active_module == 4'(i)) begin
            oled_data = module_pixel[16*i +: 16];
          end
        end
      end
      DEFUSED:  oled_data = PIXEL_DEFUSED;
      EXPLODED: oled_data = PIXEL_EXPLODED;
      default:  oled_data = home_pixel;
    endcase
  end

  // Status LEDs: solved mask, strike thermometer, and a heartbeat while armed.
  always_comb begin
    led                  = 16'h0000;
    led[NUM_MODULES-1:0] = solved_reg;
    led[13]              = (strikes >= 2'd1);
    led[14]              = (strikes >= 2'd2);
    led[15]              = (strikes == 2'd3);
    led[12]              = (state_q == ARMED) && blink;
  end

endmodule

// File: tb/tb_bomb_sequencer.sv
// Bench for bomb_sequencer: directed round scenarios plus random rounds,
// every cycle compared against a cycle-level model of the game rules.
module tb_bomb_sequencer;

  localparam int NM  = 3;
  localparam int CHZ = 10;
  localparam int TS  = 30;
  localparam int MS  = 3;
  localparam int PEN = 10;

  logic          clk;
  logic          reset_n;
  logic          arm;
  logic [NM-1:0] module_solved;
  logic [NM-1:0] module_strike;
  logic [47:0]   module_pixel;
  logic [15:0]   home_pixel;
  logic [15:0]   oled_data;
  logic          module_hold;
  logic [3:0]    active_module;
  logic [1:0]    state;
  logic [9:0]    seconds_left;
  logic [1:0]    strikes;
  logic [15:0]   led;

  int total = 0;
  int bad   = 0;

  // Reference model of the round.
  int            m_state;
  int            m_sec;
  int            m_strk;
  int            m_elapsed;
  int            m_active;
  logic [NM-1:0] m_solved;
  bit            m_blink;

  bomb_sequencer #(
    .NUM_MODULES(NM), .CLK_HZ(CHZ), .TIME_SECONDS(TS),
    .MAX_STRIKES(MS), .PENALTY_SECONDS(PEN)
  ) dut (
    .basys_clock(clk), .reset_n(reset_n), .arm(arm),
    .module_solved(module_solved), .module_strike(module_strike),
    .module_pixel(module_pixel), .home_pixel(home_pixel),
    .oled_data(oled_data), .module_hold(module_hold),
    .active_module(active_module), .state(state),
    .seconds_left(seconds_left), .strikes(strikes), .led(led)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_sec = 0; m_strk = 0; m_elapsed = 0;
    m_active = 0; m_solved = '0; m_blink = 1'b0;
  endtask

  task automatic model_edge(input bit a, input logic [NM-1:0] sol, input logic [NM-1:0] stk);
    bit tick;
    bit hit;
    if (m_state == 0) begin
      m_active = 0;
      if (a) begin
        m_state = 1; m_sec = TS; m_strk = 0; m_solved = '0;
        m_elapsed = 0; m_blink = 1'b1;
      end
    end else if (m_state == 1) begin
      m_elapsed++;
      tick = (m_elapsed % CHZ) == 0;
      hit  = (stk != '0);
      m_strk = m_strk + (hit ? 1 : 0);
      m_sec  = m_sec - (tick ? 1 : 0) - (hit ? PEN : 0);
      if (m_sec < 0) m_sec = 0;
      m_solved = m_solved | sol;
      for (int i = NM - 1; i >= 0; i--) begin
        if (!m_solved[i]) m_active = i;
      end
      if (tick) m_blink = ~m_blink;
      if (m_strk >= MS || m_sec == 0) m_state = 3;
      else if (m_solved == '1) m_state = 2;
    end else begin
      if (a) m_state = 0;
    end
  endtask

  task automatic check_all();
    logic [15:0] exp_oled;
    logic [15:0] exp_led;
    case (m_state)
      0:       exp_oled = home_pixel;
      1:       exp_oled = 16'(module_pixel >> (16 * m_active));
      2:       exp_oled = 16'h07E0;
      default: exp_oled = 16'hF800;
    endcase
    exp_led = 16'(m_solved);
    exp_led[15:13] = 3'(((1 << m_strk) - 1));
    exp_led[12] = (m_state == 1) && m_blink;
    chk("state", 32'(state), 32'(m_state));
    chk("seconds_left", 32'(seconds_left), 32'(m_sec));
    chk("strikes", 32'(strikes), 32'(m_strk));
    chk("active_module", 32'(active_module), 32'(m_active));
    chk("module_hold", 32'(module_hold), 32'(m_state != 1));
    chk("oled_data", 32'(oled_data), 32'(exp_oled));
    chk("led", 32'(led), 32'(exp_led));
  endtask

  task automatic step(input bit a, input logic [NM-1:0] sol, input logic [NM-1:0] stk);
    arm           = a;
    module_solved = sol;
    module_strike = stk;
    module_pixel  = 48'({$urandom(), $urandom()});
    home_pixel    = 16'($urandom());
    @(posedge clk);
    model_edge(a, sol, stk);
    #1;
    check_all();
  endtask

  task automatic to_idle();
    if (m_state != 0) step(1'b1, '0, '0);
  endtask

  initial begin
    logic [NM-1:0] sol;
    logic [NM-1:0] stk;
    bit a;
    int guard;

    reset_n = 1'b0; arm = 1'b0; module_solved = '0; module_strike = '0;
    module_pixel = 48'h1111_2222_3333; home_pixel = 16'hABCD;
    model_reset();
    #2;
    check_all();
    chk("reset_oled_home", 32'(oled_data), 32'h0000ABCD);
    #2 reset_n = 1'b1;

    // Reset and arm, then let the timer run out.
    step(1'b0, '0, '0);
    step(1'b1, '0, '0);
    chk("arm_state", 32'(state), 32'd1);
    chk("arm_seconds", 32'(seconds_left), 32'(TS));
    chk("arm_hold", 32'(module_hold), 32'd0);
    for (int i = 0; i < CHZ; i++) step(1'b0, '0, '0);
    chk("first_tick", 32'(seconds_left), 32'(TS - 1));
    for (int i = CHZ; i < TS * CHZ - 1; i++) step(1'b0, '0, '0);
    chk("timeout_pre", 32'(state), 32'd1);
    step(1'b0, '0, '0);
    chk("timeout_state", 32'(state), 32'd3);
    chk("timeout_oled", 32'(oled_data), 32'h0000F800);

    // Penalty with simultaneous strike bits, then strike out.
    to_idle();
    step(1'b1, '0, '0);
    step(1'b0, '0, 3'b101);
    chk("pen_strikes", 32'(strikes), 32'd1);
    chk("pen_seconds", 32'(seconds_left), 32'(TS - PEN));
    chk("pen_led", 32'(led[15:13]), 32'b001);
    step(1'b0, '0, '0);
    step(1'b0, '0, 3'b010);
    step(1'b0, '0, 3'b001);
    chk("strike_out", 32'(state), 32'd3);

    // Saturation: penalty larger than the remaining time.
    to_idle();
    step(1'b1, '0, '0);
    for (int i = 0; i < (TS - 4) * CHZ; i++) step(1'b0, '0, '0);
    chk("sat_pre", 32'(seconds_left), 32'd4);
    step(1'b0, '0, 3'b100);
    chk("sat_seconds", 32'(seconds_left), 32'd0);
    chk("sat_state", 32'(state), 32'd3);

    // Solve order and sticky solves.
    to_idle();
    step(1'b1, '0, '0);
    step(1'b0, 3'b010, '0);
    chk("solve1_active", 32'(active_module), 32'd0);
    step(1'b0, 3'b011, '0);
    chk("solve0_active", 32'(active_module), 32'd2);
    step(1'b0, 3'b010, '0);
    chk("sticky_led0", 32'(led[0]), 32'd1);
    step(1'b0, 3'b111, '0);
    chk("defused_state", 32'(state), 32'd2);
    chk("defused_oled", 32'(oled_data), 32'h000007E0);

    // Last solve and final strike together: explosion wins, then recover.
    step(1'b1, '0, '0);
    step(1'b1, '0, '0);
    step(1'b0, 3'b011, 3'b001);
    step(1'b0, 3'b011, 3'b001);
    step(1'b0, 3'b111, 3'b100);
    chk("simul_state", 32'(state), 32'd3);
    step(1'b1, '0, '0);
    chk("recover_state", 32'(state), 32'd0);
    step(1'b0, '0, '0);

    // Random rounds.
    for (int r = 0; r < 8; r++) begin
      to_idle();
      step(1'b1, '0, '0);
      sol = '0;
      guard = 0;
      while (m_state == 1 && guard < 400) begin
        if ($urandom_range(0, 29) == 0) sol = sol | NM'(1 << $urandom_range(0, NM - 1));
        if ($urandom_range(0, 59) == 0) sol = sol & ~NM'(1 << $urandom_range(0, NM - 1));
        stk = ($urandom_range(0, 39) == 0) ? NM'($urandom_range(1, 7)) : '0;
        a   = ($urandom_range(0, 99) == 0);
        step(a, sol, stk);
        guard++;
      end
      chk("round_ended", 32'(m_state != 1), 32'd1);
      for (int i = 0; i < 3; i++) step(1'b0, NM'($urandom()), NM'($urandom()));
    end

    // Asynchronous reset in the middle of a round.
    to_idle();
    step(1'b1, '0, '0);
    for (int i = 0; i < 15; i++) step(1'b0, 3'b001, (i == 4) ? 3'b010 : 3'b000);
    chk("midround_armed", 32'(state), 32'd1);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("async_seconds", 32'(seconds_left), 32'd0);
    #2 reset_n = 1'b1;
    step(1'b0, '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bomb_sequencer.md
# bomb_sequencer

Parametrised game sequencer that owns the round lifecycle for the bomb-defusal board: countdown timer, strike counter, sticky per-module solved tracking, and the win/lose decision. It generalises the top-level switch-based OLED mux and reset wiring into a state-machine-driven selector over `NUM_MODULES` minigame pixel sources. It sits between the minigame modules (flow, maze, wire-cut, …) and one `Oled_Display` instance, and drives the board LEDs.

## Interface

**Parameters**
- `NUM_MODULES`, default 3: number of minigames; legal range 1..12.
- `CLK_HZ`, default 100_000_000: `basys_clock` cycles per timer second; must be ≥ 2.
- `TIME_SECONDS`, default 300: round length in seconds; must be ≤ 1023.
- `MAX_STRIKES`, default 3: strike count that detonates; legal range 1..3.
- `PENALTY_SECONDS`, default 10: seconds removed per strike.

**Ports**
- `basys_clock` input, 1: system clock, the only clock.
- `reset_n` input, 1: asynchronous, active-low reset.
- `arm` input, 1: one-cycle pulse. In IDLE it starts a round; in DEFUSED or EXPLODED it returns to IDLE.
- `module_solved` input, NUM_MODULES: per-module solved level.
- `module_strike` input, NUM_MODULES: per-module one-cycle strike pulse.
- `module_pixel` input, 16*NUM_MODULES: RGB565 pixel from each module; module i occupies bits [16i+15:16i].
- `home_pixel` input, 16: start-screen pixel.
- `oled_data` output, 16: pixel sent to `Oled_Display`.
- `module_hold` output, 1: high means all modules are held in reset. It is low only in ARMED.
- `active_module` output, 4: index of the module currently displayed.
- `state` output, 2: IDLE=0, ARMED=1, DEFUSED=2, EXPLODED=3.
- `seconds_left` output, 10: remaining seconds.
- `strikes` output, 2: strike count.
- `led` output, 16: status LEDs.

## Operation

- **States**
  - IDLE: on `arm`, go to ARMED. Load `seconds_left`=TIME_SECONDS, `strikes`=0, `solved_reg`=0, and clear the prescaler.
  - ARMED: go to EXPLODED if `strikes_next` ≥ MAX_STRIKES or `seconds_left_next` == 0. Otherwise go to DEFUSED if `solved_next` is all ones. Otherwise stay.
  - DEFUSED / EXPLODED: hold all counters. On `arm`, go to IDLE.
  - IDLE ignores solved and strike inputs.
- **Precedence:** EXPLODED wins over DEFUSED when both are true in the same cycle.
- **Prescaler:** counts 0..CLK_HZ-1 while ARMED. At CLK_HZ-1 it wraps to 0 and issues a one-second tick.
- **Strikes:** when any bit of `module_strike` is high in an ARMED cycle, `strikes` increments by exactly 1. Several simultaneous bits count as one strike.
- **`seconds_left_next`:** `seconds_left` − tick − (strike ? PENALTY_SECONDS : 0), saturating at 0. Tick and strike in the same cycle both apply.
- **`solved_next`:** `solved_reg` | `module_solved`. Solved bits are sticky; deassertion is ignored.
- **`active_module`:** registered. Each ARMED cycle it loads the lowest index with `solved_next` bit = 0. If all are solved it holds. In IDLE it is reset to 0.
- **`oled_data`** (combinational from registered state and `active_module`):
  - IDLE: `home_pixel`.
  - ARMED: slice `active_module` of `module_pixel`.
  - DEFUSED: 16'h07E0.
  - EXPLODED: 16'hF800.
- **`led`:**
  - `[NUM_MODULES-1:0]` = `solved_reg`.
  - `[15:13]` = thermometer of `strikes` (1 → 3'b001, 2 → 3'b011, 3 → 3'b111).
  - `[12]` = 1 in ARMED, toggling on each tick.
  - All other bits are 0.

## Timing

- **Reset values** (asynchronous on `reset_n`=0):
  - state=IDLE, `seconds_left`=0, `strikes`=0, `solved_reg`=0, `active_module`=0, prescaler=0, `led`=0.
  - `module_hold`=1, `oled_data`=`home_pixel`.
- **Arm latency:** `arm` sampled at edge k gives state=ARMED, `module_hold`=0 and `seconds_left`=TIME_SECONDS after edge k.
- **First tick:** occurs CLK_HZ edges after arm. The decrement is visible on that edge.
- **Strike latency:** a strike sampled at edge k updates `strikes` and `seconds_left` after edge k. Any terminal transition takes effect on the same edge.
- **Solve latency:** a solve sampled at edge k sets `solved_reg` and updates `active_module` after edge k.
- **Terminal state:** `module_hold` rises in the same cycle state becomes terminal. Outputs are frozen until `arm`.
- **Reset mid-round:** immediate return to reset values. No partial state survives.

## Test plan

- **Reset and arm** (CLK_HZ=10, TIME_SECONDS=5): after reset, `state`=0, `module_hold`=1, `oled_data`=`home_pixel`. Pulse `arm` → next cycle `state`=1, `seconds_left`=5, `module_hold`=0.
- **Timeout:** armed with no activity → `seconds_left` reaches 4,3,2,1 at 10-cycle intervals. At cycle 50 after arm, `state`=3 and `oled_data`=16'hF800.
- **Penalty** (TIME_SECONDS=300, PENALTY_SECONDS=10): strike pulse on modules 0 and 2 in the same cycle → `strikes`=1, `seconds_left`=290, `led[15:13]`=3'b001. A third strike → `state`=3.
- **Saturation:** `seconds_left`=4, then a strike → `seconds_left`=0 and `state`=3 on the same edge.
- **Solve order** (NUM_MODULES=3): solve module 1 → `active_module` stays 0. Solve module 0 → `active_module`=2. Drop `module_solved[0]` → `led[0]` stays 1. Solve module 2 → `state`=2, `oled_data`=16'h07E0.
- **Simultaneous final events and recovery:** last solve and final strike in the same cycle → `state`=3. Pulse `arm` → `state`=0. Assert `reset_n`=0 mid-round → all outputs return to reset values immediately, without waiting for a clock edge.
